// File: rtl/n_mux_arb.sv
// N-input multiplexer with a single registered output stage, selecting a channel
// either by an explicit select input or by round-robin arbitration.
module n_mux_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_IN     = 4,
    parameter int MODE       = 1,
    localparam int SEL_W     = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   data_in,
    input  logic [NUM_IN-1:0]              in_valid,
    output logic [NUM_IN-1:0]              in_ready,
    input  logic [SEL_W-1:0]               sel,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]               out_sel,
    output logic                           out_valid,
    input  logic                           out_ready
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                  load;
    logic                  gnt_vld;
    logic [SEL_W-1:0]      gnt_idx;
    logic [SEL_W-1:0]      cand;
    logic [NUM_IN-1:0]     gnt_oh;
    logic [DATA_WIDTH-1:0] mux_data;
    int                    pos;

    assign load = !valid_q || out_ready;

    // Grant: explicit select honours only the selected channel; round-robin takes
    // the first valid channel at or above rr_ptr, wrapping past NUM_IN-1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        pos     = 0;
        if (MODE == 0) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cand = SEL_W'(i);
                if (sel == cand && in_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                pos = int'(rr_ptr_q) + k;
                if (pos >= NUM_IN) begin
                    pos = pos - NUM_IN;
                end
                cand = SEL_W'(pos);
                if (!gnt_vld && in_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        mux_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_vld && gnt_idx == SEL_W'(i)) begin
                gnt_oh[i] = 1'b1;
                mux_data  = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_ready = (load && !rst) ? gnt_oh : '0;

    always_comb begin
        data_d   = data_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            valid_d = gnt_vld;
            if (gnt_vld) begin
                data_d = mux_data;
                sel_d  = gnt_idx;
                if (MODE != 0) begin
                    rr_ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign data_out  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_n_mux_arb.sv
// Directed bench for n_mux_arb: a round-robin instance and an explicit-select
// instance share clock, reset and channel data.
module tb_n_mux_arb;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   data_in;

    logic [N-1:0]      in_valid1, in_ready1;
    logic [SW-1:0]     sel1;
    logic [DW-1:0]     data_out1;
    logic [SW-1:0]     out_sel1;
    logic              out_valid1, out_ready1;

    logic [N-1:0]      in_valid0, in_ready0;
    logic [SW-1:0]     sel0;
    logic [DW-1:0]     data_out0;
    logic [SW-1:0]     out_sel0;
    logic              out_valid0, out_ready0;

    int total = 0;
    int bad   = 0;

    n_mux_arb #(.DATA_WIDTH(DW), .NUM_IN(N), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .in_valid(in_valid1), .in_ready(in_ready1), .sel(sel1),
        .data_out(data_out1), .out_sel(out_sel1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    n_mux_arb #(.DATA_WIDTH(DW), .NUM_IN(N), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .in_valid(in_valid0), .in_ready(in_ready0), .sel(sel0),
        .data_out(data_out0), .out_sel(out_sel0),
        .out_valid(out_valid0), .out_ready(out_ready0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out1(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] s, input logic [1:0] rr);
        chk({tag, ".valid"}, 32'(out_valid1), 32'(v));
        chk({tag, ".data"},  32'(data_out1),  32'(d));
        chk({tag, ".sel"},   32'(out_sel1),   32'(s));
        chk({tag, ".rr"},    32'(dut1.rr_ptr_q), 32'(rr));
    endtask

    task automatic chk_out0(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] s);
        chk({tag, ".valid"}, 32'(out_valid0), 32'(v));
        chk({tag, ".data"},  32'(data_out0),  32'(d));
        chk({tag, ".sel"},   32'(out_sel0),   32'(s));
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid1  = 4'b1111;
        sel1       = '0;
        out_ready1 = 1'b1;
        in_valid0  = 4'b0000;
        sel0       = '0;
        out_ready0 = 1'b1;
        #2;
        chk_out1("reset", 1'b0, 8'h00, 2'd0, 2'd0);
        chk("reset.in_ready", 32'(in_ready1), 32'(4'b0000));
        chk_out0("reset0", 1'b0, 8'h00, 2'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rr.in_ready0", 32'(in_ready1), 32'(4'b0001));

        // Round-robin rotation with all channels valid
        step(); chk_out1("rr0", 1'b1, 8'hA0, 2'd0, 2'd1);
        step(); chk_out1("rr1", 1'b1, 8'hA1, 2'd1, 2'd2);
        step(); chk_out1("rr2", 1'b1, 8'hA2, 2'd2, 2'd3);
        step(); chk_out1("rr3", 1'b1, 8'hA3, 2'd3, 2'd0);
        step(); chk_out1("rr4", 1'b1, 8'hA0, 2'd0, 2'd1);
        step(); chk_out1("rr5", 1'b1, 8'hA1, 2'd1, 2'd2);

        // Backpressure while holding A1
        out_ready1 = 1'b0;
        #1;
        chk("bp.in_ready", 32'(in_ready1), 32'(4'b0000));
        for (int c = 0; c < 3; c++) begin
            step();
            chk_out1("bp.hold", 1'b1, 8'hA1, 2'd1, 2'd2);
            chk("bp.in_ready_hold", 32'(in_ready1), 32'(4'b0000));
        end
        out_ready1 = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready1), 32'(4'b0100));
        step(); chk_out1("bp.next", 1'b1, 8'hA2, 2'd2, 2'd3);

        // Sparse wrap: only channels 3 and 0, fresh data values
        data_in   = {8'h5C, 8'h11, 8'h22, 8'h3E};
        in_valid1 = 4'b1001;
        #1;
        chk("wrap.in_ready", 32'(in_ready1), 32'(4'b1000));
        step(); chk_out1("wrap3", 1'b1, 8'h5C, 2'd3, 2'd0);
        chk("wrap.in_ready2", 32'(in_ready1), 32'(4'b0001));
        step(); chk_out1("wrap0", 1'b1, 8'h3E, 2'd0, 2'd1);

        // Idle: no valid inputs
        in_valid1 = 4'b0000;
        #1;
        chk("idle.in_ready", 32'(in_ready1), 32'(4'b0000));
        step(); chk_out1("idle", 1'b0, 8'h3E, 2'd0, 2'd1);
        step(); chk_out1("idle2", 1'b0, 8'h3E, 2'd0, 2'd1);

        // Async reset between edges while a word is held
        data_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid1 = 4'b1111;
        step(); chk_out1("pre_rst", 1'b1, 8'hA1, 2'd1, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_out1("async_rst", 1'b0, 8'h00, 2'd0, 2'd0);
        chk("async_rst.in_ready", 32'(in_ready1), 32'(4'b0000));
        #2;
        rst = 1'b0;
        step(); chk_out1("post_rst", 1'b1, 8'hA0, 2'd0, 2'd1);

        // Explicit select instance
        sel0      = 2'd2;
        in_valid0 = 4'b1111;
        #1;
        chk("mode0.in_ready", 32'(in_ready0), 32'(4'b0100));
        step(); chk_out0("mode0.a", 1'b1, 8'hA2, 2'd2);
        chk("mode0.in_ready_b", 32'(in_ready0), 32'(4'b0100));
        step(); chk_out0("mode0.b", 1'b1, 8'hA2, 2'd2);
        chk("mode0.rr_const", 32'(dut0.rr_ptr_q), 32'(0));

        sel0      = 2'd3;
        in_valid0 = 4'b0111;
        #1;
        chk("mode0.unsel_ready", 32'(in_ready0), 32'(4'b0000));
        step(); chk_out0("mode0.novalid", 1'b0, 8'hA2, 2'd2);

        // Select change during a stall takes effect on the next load cycle
        sel0      = 2'd2;
        in_valid0 = 4'b1111;
        step(); chk_out0("mode0.c", 1'b1, 8'hA2, 2'd2);
        out_ready0 = 1'b0;
        sel0       = 2'd1;
        #1;
        chk("mode0.stall_ready", 32'(in_ready0), 32'(4'b0000));
        step(); chk_out0("mode0.stall", 1'b1, 8'hA2, 2'd2);
        out_ready0 = 1'b1;
        #1;
        chk("mode0.sel1_ready", 32'(in_ready0), 32'(4'b0010));
        step(); chk_out0("mode0.sel1", 1'b1, 8'hA1, 2'd1);
        chk("mode0.rr_const2", 32'(dut0.rr_ptr_q), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
